wb_stage: RTL

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/wb_stage_pkg.sv | 59 +++++
 rtl/wb_stage_if.sv | 30 +++
 rtl/wb_stage_load_align.sv | 53 +++++
 rtl/wb_stage.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/wb_stage_pkg.sv
// Shared definitions for the write-back stage: opcodes, NOP encoding,
// load size selectors, FSM state type and the opcode classifier.
package wb_stage_pkg;

    localparam logic [6:0] OP_LOAD    = 7'b0000011;
    localparam logic [6:0] OP_STORE   = 7'b0100011;
    localparam logic [6:0] OP_BRANCH  = 7'b1100011;
    localparam logic [6:0] OP_JAL     = 7'b1101111;
    localparam logic [6:0] OP_JALR    = 7'b1100111;
    localparam logic [6:0] OP_LUI     = 7'b0110111;
    localparam logic [6:0] OP_AUIPC   = 7'b0010111;
    localparam logic [6:0] OP_OPIMM   = 7'b0010011;
    localparam logic [6:0] OP_OP      = 7'b0110011;
    localparam logic [6:0] OP_OPIMM32 = 7'b0011011;
    localparam logic [6:0] OP_OP32    = 7'b0111011;

    // A bubble is written back as addi x0, x0, 0
    localparam logic [6:0]  NOP_OPCODE = OP_OPIMM;
    localparam logic [4:0]  NOP_RD     = 5'd0;
    localparam logic [2:0]  NOP_FUNC3  = 3'd0;
    localparam logic [6:0]  NOP_FUNC7  = 7'd0;
    localparam logic [11:0] NOP_IMM    = 12'd0;

    localparam logic [2:0] F3_LB      = 3'b000;
    localparam logic [2:0] F3_LH      = 3'b001;
    localparam logic [2:0] F3_LW      = 3'b010;
    localparam logic [2:0] F3_LD      = 3'b011;
    localparam logic [2:0] F3_LBU     = 3'b100;
    localparam logic [2:0] F3_LHU     = 3'b101;
    localparam logic [2:0] F3_LWU     = 3'b110;
    localparam logic [2:0] F3_ILLEGAL = 3'b111;

    typedef enum logic [0:0] {
        ST_IDLE      = 1'b0,
        ST_LOAD_WAIT = 1'b1
    } wb_state_t;

    typedef enum logic [2:0] {
        CLS_UNKNOWN,
        CLS_LINK,
        CLS_ALU,
        CLS_LOAD,
        CLS_NOWRITE
    } op_class_t;

    function automatic op_class_t classify(input logic [6:0] opcode);
        op_class_t cls;
        case (opcode)
            OP_JAL, OP_JALR:                       cls = CLS_LINK;
            OP_LUI, OP_AUIPC, OP_OPIMM, OP_OP,
            OP_OPIMM32, OP_OP32:                   cls = CLS_ALU;
            OP_LOAD:                               cls = CLS_LOAD;
            OP_STORE, OP_BRANCH:                   cls = CLS_NOWRITE;
            default:                               cls = CLS_UNKNOWN;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/wb_stage_if.sv
// MEM-to-WB handshake and register-file write port of the write-back stage.
interface wb_stage_if #(
    parameter int XLEN = 64
);
    logic            in_valid;
    logic [6:0]      in_opcode;
    logic [4:0]      in_rd;
    logic [2:0]      in_func3;
    logic [XLEN-1:0] in_alu;
    logic [XLEN-1:0] in_pc4;
    logic            mem_rvalid;
    logic [XLEN-1:0] mem_rdata;
    logic            stall;
    logic [XLEN-1:0] wdata;
    logic [4:0]      wrd;
    logic [6:0]      wopcode;
    logic            wb_err;

    modport master (
        output in_valid, in_opcode, in_rd, in_func3, in_alu, in_pc4,
        output mem_rvalid, mem_rdata,
        input  stall, wdata, wrd, wopcode, wb_err
    );

    modport slave (
        input  in_valid, in_opcode, in_rd, in_func3, in_alu, in_pc4,
        input  mem_rvalid, mem_rdata,
        output stall, wdata, wrd, wopcode, wb_err
    );
endinterface

// File: rtl/wb_stage_load_align.sv
// Extracts and extends load data from an aligned doubleword, and flags
// misaligned accesses and the reserved size encoding.
module load_align
    import wb_stage_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [2:0]      addr,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] value,
    output logic            misaligned,
    output logic            illegal
);
    logic [XLEN-1:0] lane;
    logic [7:0]      lane_byte [0:7];

    assign lane = rdata >> {addr, 3'b000};

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_byte
            assign lane_byte[gi] = lane[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        value = '0;
        case (func3)
            F3_LB:  value = {{(XLEN-8){lane_byte[0][7]}}, lane_byte[0]};
            F3_LH:  value = {{(XLEN-16){lane_byte[1][7]}}, lane_byte[1], lane_byte[0]};
            F3_LW:  value = {{(XLEN-32){lane_byte[3][7]}}, lane[31:0]};
            F3_LD:  value = lane;
            F3_LBU: value = {{(XLEN-8){1'b0}}, lane_byte[0]};
            F3_LHU: value = {{(XLEN-16){1'b0}}, lane_byte[1], lane_byte[0]};
            F3_LWU: value = {{(XLEN-32){1'b0}}, lane[31:0]};
            default: value = '0;
        endcase
    end

    always_comb begin
        misaligned = 1'b0;
        case (func3)
            F3_LH, F3_LHU: misaligned = addr[0];
            F3_LW, F3_LWU: misaligned = |addr[1:0];
            F3_LD:         misaligned = |addr;
            default:       misaligned = 1'b0;
        endcase
    end

    assign illegal = (func3 == F3_ILLEGAL);

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: selects the register-file write value, waits for late
// load responses with a timeout, and keeps a sticky error flag.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int XLEN         = 64,
    parameter int LOAD_TIMEOUT = 255
) (
    input  logic      clk,
    input  logic      rst,
    wb_stage_if.slave bus
);
    wb_state_t       state_reg;
    logic [7:0]      cnt_reg;
    logic [4:0]      cap_rd_reg;
    logic [2:0]      cap_func3_reg;
    logic [2:0]      cap_addr_reg;
    logic [6:0]      cap_opcode_reg;
    logic [XLEN-1:0] wdata_reg;
    logic [4:0]      wrd_reg;
    logic [6:0]      wopcode_reg;
    logic            err_reg;

    logic            in_wait;
    logic            issue_wait;
    logic [2:0]      la_addr;
    logic [2:0]      la_func3;
    logic [XLEN-1:0] la_value;
    logic            la_misaligned;
    logic            la_illegal;
    logic [4:0]      ld_rd;
    logic            ld_bad;
    logic [4:0]      ld_wrd;
    logic [XLEN-1:0] ld_wdata;
    logic [XLEN-1:0] res_wdata;
    logic [4:0]      res_wrd;
    logic [6:0]      res_wopcode;
    logic            res_err;

    assign in_wait    = (state_reg == ST_LOAD_WAIT);
    assign issue_wait = (state_reg == ST_IDLE) && bus.in_valid &&
                        (bus.in_opcode == OP_LOAD) && !bus.mem_rvalid;
    assign bus.stall  = in_wait || issue_wait;

    // The aligner sees the live request in IDLE and the captured one while waiting
    assign la_addr  = in_wait ? cap_addr_reg  : bus.in_alu[2:0];
    assign la_func3 = in_wait ? cap_func3_reg : bus.in_func3;
    assign ld_rd    = in_wait ? cap_rd_reg    : bus.in_rd;

    load_align #(
        .XLEN (XLEN)
    ) u_load_align (
        .addr       (la_addr),
        .func3      (la_func3),
        .rdata      (bus.mem_rdata),
        .value      (la_value),
        .misaligned (la_misaligned),
        .illegal    (la_illegal)
    );

    assign ld_bad   = la_misaligned || la_illegal;
    assign ld_wrd   = ld_bad ? 5'd0 : ld_rd;
    assign ld_wdata = (ld_wrd == 5'd0) ? '0 : la_value;

    always_comb begin
        res_wdata   = '0;
        res_wrd     = NOP_RD;
        res_wopcode = NOP_OPCODE;
        res_err     = 1'b0;
        if (bus.in_valid) begin
            case (classify(bus.in_opcode))
                CLS_LINK: begin
                    res_wopcode = bus.in_opcode;
                    res_wrd     = bus.in_rd;
                    res_wdata   = bus.in_pc4;
                end
                CLS_ALU: begin
                    res_wopcode = bus.in_opcode;
                    res_wrd     = bus.in_rd;
                    res_wdata   = bus.in_alu;
                end
                CLS_LOAD: begin
                    res_wopcode = bus.in_opcode;
                    res_wrd     = ld_wrd;
                    res_wdata   = ld_wdata;
                    res_err     = ld_bad;
                end
                CLS_NOWRITE: begin
                    res_wopcode = bus.in_opcode;
                end
                default: begin
                    res_wopcode = NOP_OPCODE;
                end
            endcase
            if (res_wrd == 5'd0) begin
                res_wdata = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= 8'd0;
            cap_rd_reg     <= 5'd0;
            cap_func3_reg  <= 3'd0;
            cap_addr_reg   <= 3'd0;
            cap_opcode_reg <= 7'd0;
            wdata_reg      <= '0;
            wrd_reg        <= NOP_RD;
            wopcode_reg    <= NOP_OPCODE;
            err_reg        <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (issue_wait) begin
                        state_reg      <= ST_LOAD_WAIT;
                        cnt_reg        <= 8'd0;
                        cap_rd_reg     <= bus.in_rd;
                        cap_func3_reg  <= bus.in_func3;
                        cap_addr_reg   <= bus.in_alu[2:0];
                        cap_opcode_reg <= bus.in_opcode;
                        wdata_reg      <= '0;
                        wrd_reg        <= NOP_RD;
                        wopcode_reg    <= NOP_OPCODE;
                    end else begin
                        wdata_reg   <= res_wdata;
                        wrd_reg     <= res_wrd;
                        wopcode_reg <= res_wopcode;
                        err_reg     <= err_reg | res_err;
                    end
                end
                ST_LOAD_WAIT: begin
                    // A response arriving on the last allowed cycle still wins
                    if (bus.mem_rvalid) begin
                        state_reg   <= ST_IDLE;
                        wdata_reg   <= ld_wdata;
                        wrd_reg     <= ld_wrd;
                        wopcode_reg <= cap_opcode_reg;
                        err_reg     <= err_reg | ld_bad;
                    end else if (cnt_reg == 8'(LOAD_TIMEOUT - 1)) begin
                        state_reg   <= ST_IDLE;
                        cnt_reg     <= cnt_reg + 8'd1;
                        err_reg     <= 1'b1;
                        wdata_reg   <= '0;
                        wrd_reg     <= NOP_RD;
                        wopcode_reg <= NOP_OPCODE;
                    end else begin
                        cnt_reg     <= cnt_reg + 8'd1;
                        wdata_reg   <= '0;
                        wrd_reg     <= NOP_RD;
                        wopcode_reg <= NOP_OPCODE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.wdata   = wdata_reg;
    assign bus.wrd     = wrd_reg;
    assign bus.wopcode = wopcode_reg;
    assign bus.wb_err  = err_reg;

endmodule
